// File: rtl/object_mapper.sv
// object_mapper: sprite-style colour mapper for a raster scan.
//   Per-object shadow registers are latched on frame_start so object moves
//   never tear mid-frame. The pixel path is a fixed 3-stage pipeline:
//     S1 dx/dy per object, S2 per-object hit test, S3 priority colour select.
//   Overlaps seen during a frame are reported on `collision` at the next
//   frame_start.
// Ports:
//   Clk, Reset (async, active low)
//   frame_start, pix_valid, DrawX, DrawY          : scan inputs
//   obj_x/obj_y/obj_size [NUM_OBJ*COORD_W]        : centre and half-size
//   obj_shape (0 square, 1 circle), obj_en        : per object
//   obj_color [NUM_OBJ*24]                        : {R,G,B} per object
//   Red/Green/Blue, rgb_valid                     : registered pixel out
//   collision [NUM_OBJ]                           : previous-frame overlaps

// Per-object lane: S1 offset registers and S2 hit register.
module object_mapper_lane #(
    parameter int COORD_W = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_size,
    input  logic               obj_shape,
    input  logic               obj_en,
    input  logic [23:0]        obj_color,
    output logic               hit,
    output logic [23:0]        color
);
    localparam int SQ_W = 2*COORD_W + 4;

    // S1: offsets plus the object attributes that travel with the pixel,
    // so a shadow update behind this pixel cannot affect it.
    logic signed [COORD_W+1:0] dx, dy;
    logic [COORD_W-1:0]        size1;
    logic                      shape1, en1;
    logic [23:0]               color1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dx     <= '0;
            dy     <= '0;
            size1  <= '0;
            shape1 <= 1'b0;
            en1    <= 1'b0;
            color1 <= '0;
        end else begin
            dx     <= $signed({2'b00, draw_x} - {2'b00, obj_x});
            dy     <= $signed({2'b00, draw_y} - {2'b00, obj_y});
            size1  <= obj_size;
            shape1 <= obj_shape;
            en1    <= obj_en;
            color1 <= obj_color;
        end
    end

    // Magnitudes fit in COORD_W+1 bits; squares are formed unsigned at a
    // width that cannot overflow even for the sum of two squares.
    logic [COORD_W+1:0] ndx, ndy;
    logic [COORD_W:0]   adx, ady;
    logic [SQ_W-1:0]    dist2, size2;
    logic               hit_sq, hit_c, hit_d;

    always_comb begin
        ndx    = -dx;
        ndy    = -dy;
        adx    = dx[COORD_W+1] ? ndx[COORD_W:0] : dx[COORD_W:0];
        ady    = dy[COORD_W+1] ? ndy[COORD_W:0] : dy[COORD_W:0];
        dist2  = SQ_W'(adx) * SQ_W'(adx) + SQ_W'(ady) * SQ_W'(ady);
        size2  = SQ_W'(size1) * SQ_W'(size1);
        hit_sq = (adx <= {1'b0, size1}) && (ady <= {1'b0, size1});
        hit_c  = dist2 <= size2;
        hit_d  = en1 && (shape1 ? hit_c : hit_sq);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hit   <= 1'b0;
            color <= '0;
        end else begin
            hit   <= hit_d;
            color <= color1;
        end
    end
endmodule

module object_mapper #(
    parameter int         NUM_OBJ = 4,
    parameter int         COORD_W = 10,
    parameter logic [7:0] BG_BLUE = 8'h44
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_start,
    input  logic                       pix_valid,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_size,
    input  logic [NUM_OBJ-1:0]         obj_shape,
    input  logic [NUM_OBJ-1:0]         obj_en,
    input  logic [NUM_OBJ*24-1:0]      obj_color,
    output logic [7:0]                 Red,
    output logic [7:0]                 Green,
    output logic [7:0]                 Blue,
    output logic                       rgb_valid,
    output logic [NUM_OBJ-1:0]         collision
);
    localparam int STAGES = 3;

    // Shadow copies, only updated on frame_start.
    logic [NUM_OBJ-1:0][COORD_W-1:0] sh_x, sh_y, sh_size;
    logic [NUM_OBJ-1:0]              sh_shape, sh_en;
    logic [NUM_OBJ-1:0][23:0]        sh_color;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_size  <= '0;
            sh_shape <= '0;
            sh_en    <= '0;
            sh_color <= '0;
        end else if (frame_start) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_size  <= obj_size;
            sh_shape <= obj_shape;
            sh_en    <= obj_en;
            sh_color <= obj_color;
        end
    end

    // Valid shift register; bit 0 is the live input.
    logic [STAGES:1] vld_q;
    wire  [STAGES:0] vld_pipe = {vld_q, pix_valid};

    logic [COORD_W-1:0] drawx1, drawx2;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_q  <= '0;
            drawx1 <= '0;
            drawx2 <= '0;
        end else begin
            vld_q  <= vld_pipe[STAGES-1:0];
            drawx1 <= DrawX;
            drawx2 <= drawx1;
        end
    end

    logic [NUM_OBJ-1:0]       hit2;
    logic [NUM_OBJ-1:0][23:0] color2;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_lane
        object_mapper_lane #(.COORD_W(COORD_W)) u_lane (
            .Clk       (Clk),
            .Reset     (Reset),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .obj_x     (sh_x[i]),
            .obj_y     (sh_y[i]),
            .obj_size  (sh_size[i]),
            .obj_shape (sh_shape[i]),
            .obj_en    (sh_en[i]),
            .obj_color (sh_color[i]),
            .hit       (hit2[i]),
            .color     (color2[i])
        );
    end

    // Lowest index wins: scan downwards so the last assignment is the winner.
    logic [23:0]        sel_color;
    logic               any_hit;
    logic [COORD_W-1:0] x_sh;
    logic [7:0]         bg_red;

    always_comb begin
        sel_color = '0;
        any_hit   = 1'b0;
        for (int i = NUM_OBJ-1; i >= 0; i--) begin
            if (hit2[i]) begin
                sel_color = color2[i];
                any_hit   = 1'b1;
            end
        end
        // Background red ramps down with DrawX[9:3].
        x_sh   = (drawx2 >> 3) & COORD_W'(7'h7F);
        bg_red = 8'h4F - 8'(x_sh);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else if (!vld_pipe[2]) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else if (any_hit) begin
            {Red, Green, Blue} <= sel_color;
        end else begin
            Red   <= bg_red;
            Green <= 8'h00;
            Blue  <= BG_BLUE;
        end
    end

    assign rgb_valid = vld_q[STAGES];

    // Collision: any valid S2 pixel with two or more hits contributes.
    logic               multi_hit;
    logic [NUM_OBJ-1:0] coll_acc, coll_next;

    always_comb begin
        multi_hit = (hit2 & (hit2 - NUM_OBJ'(1))) != '0;
        coll_next = coll_acc | ((vld_pipe[2] && multi_hit) ? hit2 : '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            coll_acc  <= '0;
            collision <= '0;
        end else if (frame_start) begin
            collision <= coll_next;
            coll_acc  <= '0;
        end else begin
            coll_acc  <= coll_next;
        end
    end
endmodule
